// File: rtl/fp_div_writeback_if.sv
// Handshake bundle between the FP divider, the writeback stage and the FP register-file write port.
// The slave modport is the writeback stage's view; the master modport is the surrounding datapath.
interface fp_div_writeback_if #(
    parameter int unsigned DEST_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_result;
    logic [DEST_W-1:0] in_dest;
    logic              in_dbz;
    logic              in_ovf;
    logic              in_unf;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [DEST_W-1:0] out_dest;

    modport slave (
        input  in_valid, in_result, in_dest, in_dbz, in_ovf, in_unf, out_ready,
        output in_ready, out_valid, out_result, out_dest
    );

    modport master (
        output in_valid, in_result, in_dest, in_dbz, in_ovf, in_unf, out_ready,
        input  in_ready, out_valid, out_result, out_dest
    );
endinterface

// File: rtl/fp_div_writeback.sv
// FP divider writeback stage: 2-entry result buffer, valid/ready toward the register file,
// sticky {inv, dbz, ovf, unf} flags. Optional exception trapping under `FP_DIV_TRAP_EN.
module fp_div_writeback #(
    parameter int unsigned DEST_W   = 5,
    parameter logic [31:0] QNAN_OUT = 32'h7FC00000
) (
    input  logic                     clk,
    input  logic                     rst_b,
    fp_div_writeback_if.slave        bus,
    input  logic                     flags_clr,
    output logic [3:0]               flags
`ifdef FP_DIV_TRAP_EN
    ,
    input  logic [3:0]               trap_mask,
    output logic                     trap_req,
    output logic [3:0]               trap_cause,
    input  logic                     trap_ack
`endif
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} occ_e;

    occ_e              state_q, state_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [31:0]       res_q  [2];
    logic [DEST_W-1:0] dest_q [2];
    logic [3:0]        flags_q, flags_d;
    logic [3:0]        exc;
    logic              push, pop;
    logic              trap_active;

    assign exc  = {bus.in_result == QNAN_OUT, bus.in_dbz, bus.in_ovf, bus.in_unf};
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // in_ready is a function of registered state only; no path from any input.
    assign bus.in_ready   = (state_q != StFull) && !trap_active;
    assign bus.out_valid  = (state_q != StEmpty);
    assign bus.out_result = bus.out_valid ? res_q[rd_ptr_q] : '0;
    assign bus.out_dest   = bus.out_valid ? dest_q[rd_ptr_q] : '0;
    assign flags          = flags_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        unique case (state_q)
            StEmpty: if (push) state_d = StOne;
            StOne: begin
                if (push && !pop) state_d = StFull;
                else if (!push && pop) state_d = StEmpty;
            end
            StFull:  if (pop) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    // A clear and a same-cycle push: the pushed flags win.
    always_comb begin
        flags_d = flags_clr ? 4'b0000 : flags_q;
        if (push) flags_d = flags_d | exc;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= StEmpty;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            flags_q   <= 4'b0000;
            res_q[0]  <= '0;
            res_q[1]  <= '0;
            dest_q[0] <= '0;
            dest_q[1] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            flags_q  <= flags_d;
            if (push) begin
                res_q[wr_ptr_q]  <= bus.in_result;
                dest_q[wr_ptr_q] <= bus.in_dest;
            end
        end
    end

`ifdef FP_DIV_TRAP_EN
    logic       trap_q, trap_d;
    logic [3:0] cause_q, cause_d;

    // The buffer keeps draining while trapped; only new pushes are held off.
    always_comb begin
        trap_d  = trap_q;
        cause_d = cause_q;
        if (trap_q && trap_ack) begin
            trap_d  = 1'b0;
            cause_d = 4'b0000;
        end else if (push && |(exc & trap_mask)) begin
            trap_d  = 1'b1;
            cause_d = exc;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            trap_q  <= 1'b0;
            cause_q <= 4'b0000;
        end else begin
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    assign trap_active = trap_q;
    assign trap_req    = trap_q;
    assign trap_cause  = cause_q;
`else
    assign trap_active = 1'b0;
`endif

endmodule

// File: tb/tb_fp_div_writeback.sv
// Directed self-checking bench for fp_div_writeback; trap checks build with `FP_DIV_TRAP_EN.
module tb_fp_div_writeback;

    logic       clk;
    logic       rst_b;
    logic       flags_clr;
    logic [3:0] flags;
`ifdef FP_DIV_TRAP_EN
    logic [3:0] trap_mask;
    logic       trap_req;
    logic [3:0] trap_cause;
    logic       trap_ack;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fp_div_writeback_if #(.DEST_W(5)) bus ();

    fp_div_writeback #(
        .DEST_W   (5),
        .QNAN_OUT (32'h7FC00000)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .bus        (bus),
        .flags_clr  (flags_clr),
        .flags      (flags)
`ifdef FP_DIV_TRAP_EN
        ,
        .trap_mask  (trap_mask),
        .trap_req   (trap_req),
        .trap_cause (trap_cause),
        .trap_ack   (trap_ack)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] dst,
                         input logic dbz, input logic ovf, input logic unf);
        bus.in_valid  = v;
        bus.in_result = res;
        bus.in_dest   = dst;
        bus.in_dbz    = dbz;
        bus.in_ovf    = ovf;
        bus.in_unf    = unf;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_result = 'x;
        bus.in_dest   = 'x;
        bus.in_dbz    = 1'bx;
        bus.in_ovf    = 1'bx;
        bus.in_unf    = 1'bx;
    endtask

    initial begin
        rst_b         = 1'b0;
        flags_clr     = 1'b0;
        bus.out_ready = 1'b0;
        idle();
`ifdef FP_DIV_TRAP_EN
        trap_mask = 4'b0000;
        trap_ack  = 1'b0;
`endif
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_out_dest", 32'(bus.out_dest), 32'd0);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef FP_DIV_TRAP_EN
        check("rst_trap_req", 32'(trap_req), 32'd0);
        check("rst_trap_cause", 32'(trap_cause), 32'd0);
`endif
        @(negedge clk);
        rst_b = 1'b1;
        tick();

        // Single push, one-cycle latency.
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h40000000, 5'd3, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("lat_out_valid", 32'(bus.out_valid), 32'd1);
        check("lat_out_result", bus.out_result, 32'h40000000);
        check("lat_out_dest", 32'(bus.out_dest), 32'd3);
        check("lat_flags", 32'(flags), 32'h0);
        tick();
        check("drain_empty", 32'(bus.out_valid), 32'd0);

        // Fill with A, B while stalled; C held off.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h3F800000, 5'd1, 1'b0, 1'b0, 1'b0);
        tick();
        check("fill_one_ready", 32'(bus.in_ready), 32'd1);
        drive(1'b1, 32'h40400000, 5'd2, 1'b0, 1'b0, 1'b0);
        tick();
        check("full_in_ready", 32'(bus.in_ready), 32'd0);
        drive(1'b1, 32'h40800000, 5'd4, 1'b0, 1'b0, 1'b0);
        tick();
        check("full_hold_ready", 32'(bus.in_ready), 32'd0);
        check("full_head_a", bus.out_result, 32'h3F800000);
        check("full_head_a_dest", 32'(bus.out_dest), 32'd1);

        // Full: pop and in_valid together -> only the pop happens.
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("pop_head_b", bus.out_result, 32'h40400000);
        check("pop_head_b_dest", 32'(bus.out_dest), 32'd2);
        check("pop_reopens", 32'(bus.in_ready), 32'd1);
        tick();
        idle();
        check("c_accepted_full", 32'(bus.in_ready), 32'd0);
        check("c_head_still_b", bus.out_result, 32'h40400000);
        bus.out_ready = 1'b1;
        tick();
        check("order_c", bus.out_result, 32'h40800000);
        check("order_c_dest", 32'(bus.out_dest), 32'd4);
        tick();
        check("order_empty", 32'(bus.out_valid), 32'd0);

        // Sticky flags and clear-vs-set.
        drive(1'b1, 32'h3F800000, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        check("flag_dbz", 32'(flags), 32'h4);
        drive(1'b1, 32'h7FC00000, 5'd6, 1'b0, 1'b0, 1'b0);
        tick();
        check("flag_inv_dbz", 32'(flags), 32'hC);
        flags_clr = 1'b1;
        drive(1'b1, 32'h3F800000, 5'd7, 1'b0, 1'b1, 1'b0);
        tick();
        flags_clr = 1'b0;
        idle();
        check("flag_clr_set_wins", 32'(flags), 32'h2);
        tick();
        check("flag_pop_no_update", 32'(flags), 32'h2);

        // Async reset while full.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h41000000, 5'd8, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'h41100000, 5'd9, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        check("pre_rst_full", 32'(bus.in_ready), 32'd0);
        check("pre_rst_flags", 32'(flags), 32'h3);
        #2;
        rst_b = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_flags", 32'(flags), 32'h0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_b = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
        tick();
        check("post_rst_no_stale2", 32'(bus.out_valid), 32'd0);

`ifdef FP_DIV_TRAP_EN
        // Masked exception traps; buffer still drains; ack releases.
        trap_mask     = 4'b0100;
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h3F800000, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        check("trap_req", 32'(trap_req), 32'd1);
        check("trap_cause", 32'(trap_cause), 32'h4);
        check("trap_in_ready", 32'(bus.in_ready), 32'd0);
        check("trap_entry_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("trap_drained", 32'(bus.out_valid), 32'd0);
        check("trap_still_req", 32'(trap_req), 32'd1);
        check("trap_still_blocked", 32'(bus.in_ready), 32'd0);
        trap_ack = 1'b1;
        tick();
        trap_ack = 1'b0;
        check("ack_trap_req", 32'(trap_req), 32'd0);
        check("ack_trap_cause", 32'(trap_cause), 32'd0);
        check("ack_in_ready", 32'(bus.in_ready), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
